// File: rtl/icache_dual.sv
`default_nettype none
// ============================================================================
// Module   : icache_dual
// Purpose  : Direct-mapped instruction cache, one word per line, with two
//            independent combinational lookup ports, fill, snoop and flush.
// Revision : 1.0 - initial release
// ============================================================================
module icache_dual #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hit1,
    output logic [31:0]       data1,
    output logic              hit2,
    output logic [31:0]       data2,
    input  logic              fill_valid,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [31:0]       fill_data,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              flush
);

    localparam int c_TAG_W   = ADDR_W - IDX_W - 2;
    localparam int c_ENTRIES = 1 << IDX_W;

    logic [c_ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0]   r_tag  [c_ENTRIES];
    logic [31:0]          r_data [c_ENTRIES];

    logic [IDX_W-1:0]   w_fill_idx;
    logic [c_TAG_W-1:0] w_fill_tag;
    logic [IDX_W-1:0]   w_snoop_idx;
    logic [c_TAG_W-1:0] w_snoop_tag;
    logic               w_snoop_kill_old;
    logic               w_snoop_kill_new;

    logic [1:0][ADDR_W-1:0] w_rd_addr;
    logic [1:0]             w_hit;
    logic [1:0][31:0]       w_rdata;
    logic                   w_unused;

    assign w_fill_idx  = fill_addr[IDX_W+1:2];
    assign w_fill_tag  = fill_addr[ADDR_W-1:IDX_W+2];
    assign w_snoop_idx = snoop_addr[IDX_W+1:2];
    assign w_snoop_tag = snoop_addr[ADDR_W-1:IDX_W+2];

    // Snoop kills the resident line when its tag matches, and also kills a
    // same-edge fill of that exact address so stale code never survives.
    assign w_snoop_kill_old = snoop_valid && r_valid[w_snoop_idx] &&
                              (r_tag[w_snoop_idx] == w_snoop_tag);
    assign w_snoop_kill_new = snoop_valid && fill_valid &&
                              (w_fill_idx == w_snoop_idx) && (w_fill_tag == w_snoop_tag);

    assign w_unused = ^{rd_addr1[1:0], rd_addr2[1:0], fill_addr[1:0], snoop_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_valid <= '0;
            end else begin
                if (w_snoop_kill_old) r_valid[w_snoop_idx] <= 1'b0;
                if (fill_valid)       r_valid[w_fill_idx]  <= 1'b1;
                if (w_snoop_kill_new) r_valid[w_snoop_idx] <= 1'b0;
            end
        end
    end

    // Payload arrays are qualified by r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rdy && fill_valid) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= fill_data;
        end
    end

    assign w_rd_addr = {rd_addr2, rd_addr1};

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            logic [IDX_W-1:0]   w_idx;
            logic [c_TAG_W-1:0] w_tag;
            assign w_idx      = w_rd_addr[p][IDX_W+1:2];
            assign w_tag      = w_rd_addr[p][ADDR_W-1:IDX_W+2];
            assign w_hit[p]   = !rst && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
            assign w_rdata[p] = w_hit[p] ? r_data[w_idx] : 32'h0;
        end
    endgenerate

    assign hit1  = w_hit[0];
    assign data1 = w_rdata[0];
    assign hit2  = w_hit[1];
    assign data2 = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_icache_dual.sv
`default_nettype none
// Testbench for icache_dual: table of per-cycle vectors plus a reset-during-fill
// sequence; expectations flow through a scoreboard queue.
module tb_icache_dual;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] rd_addr1 = '0, rd_addr2 = '0;
    logic        hit1, hit2;
    logic [31:0] data1, data2;
    logic        fill_valid = 1'b0;
    logic [31:0] fill_addr = '0, fill_data = '0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = '0;
    logic        flush = 1'b0;

    int checks   = 0;
    int failures = 0;

    icache_dual #(.ADDR_W(32), .IDX_W(7)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hit1(hit1), .data1(data1), .hit2(hit2), .data2(data2),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, fill, snoop, flush;
        logic [31:0] faddr, fdata, saddr, rd1, rd2;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    typedef struct {
        string       name;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic r, input logic f, input logic s, input logic fl,
                       input logic [31:0] fa, input logic [31:0] fd, input logic [31:0] sa,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic h1, input logic [31:0] d1,
                       input logic h2, input logic [31:0] d2);
        vec_t v;
        v.rdy = r; v.fill = f; v.snoop = s; v.flush = fl;
        v.faddr = fa; v.fdata = fd; v.saddr = sa; v.rd1 = a1; v.rd2 = a2;
        v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input string name, input logic h1, input logic [31:0] d1,
                            input logic h2, input logic [31:0] d2);
        exp_t e;
        e.name = name; e.h1 = h1; e.d1 = d1; e.h2 = h2; e.d2 = d2;
        sb.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (hit1 !== e.h1 || data1 !== e.d1 || hit2 !== e.h2 || data2 !== e.d2) begin
            failures++;
            $display("FAIL %s: got hit1=%0b data1=%h hit2=%0b data2=%h, want hit1=%0b data1=%h hit2=%0b data2=%h",
                     e.name, hit1, data1, hit2, data2, e.h1, e.d1, e.h2, e.d2);
        end
    endtask

    initial begin
        // Outputs must be forced low while reset is held.
        #2;
        push_exp("reset_hold", 1'b0, 32'h0, 1'b0, 32'h0);
        compare_next();
        @(negedge clk);
        rst = 1'b0;

        //   rdy fill snp fl  faddr         fdata         saddr         rd1           rd2           h1 d1            h2 d2
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h0,        32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 1, 0, 0, 32'h10,       32'h513,      32'h0,  32'h10,       32'h14,       0, 32'h0,        0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h10,       32'h14,       1, 32'h513,      0, 32'h0);
        add(1, 1, 0, 0, 32'h210,      32'h00100093, 32'h0,  32'h10,       32'h210,      1, 32'h513,      0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h10,       32'h210,      0, 32'h0,        1, 32'h00100093);
        add(1, 1, 0, 0, 32'h10,       32'h513,      32'h0,  32'h210,      32'h10,       1, 32'h00100093, 0, 32'h0);
        add(1, 0, 1, 0, 32'h0,        32'h0,        32'h210, 32'h10,      32'h210,      1, 32'h513,      0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h10,       32'h210,      1, 32'h513,      0, 32'h0);
        add(1, 0, 1, 0, 32'h0,        32'h0,        32'h10, 32'h10,       32'h0,        1, 32'h513,      0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h10,       32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 1, 1, 0, 32'h20,       32'hAAAA,     32'h20, 32'h20,       32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 1, 0, 0, 32'h44,       32'h2222,     32'h0,  32'h20,       32'h44,       0, 32'h0,        0, 32'h0);
        add(1, 1, 1, 0, 32'h48,       32'h3333,     32'h44, 32'h44,       32'h48,       1, 32'h2222,     0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h44,       32'h4B,       0, 32'h0,        1, 32'h3333);
        add(1, 1, 0, 1, 32'h24,       32'h5555,     32'h0,  32'h48,       32'h24,       1, 32'h3333,     0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h24,       32'h48,       0, 32'h0,        0, 32'h0);
        add(0, 1, 0, 0, 32'h30,       32'h7777,     32'h0,  32'h30,       32'h0,        0, 32'h0,        0, 32'h0);
        add(1, 1, 0, 0, 32'h50,       32'h9999,     32'h0,  32'h30,       32'h50,       0, 32'h0,        0, 32'h0);
        add(0, 0, 1, 1, 32'h0,        32'h0,        32'h50, 32'h50,       32'h0,        1, 32'h9999,     0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'h50,       32'h30,       1, 32'h9999,     0, 32'h0);
        add(1, 1, 0, 0, 32'hFFFFFFFC, 32'hDEADBEEF, 32'h0,  32'h50,       32'h0,        1, 32'h9999,     0, 32'h0);
        add(1, 1, 0, 0, 32'h1FC,      32'h1234,     32'h0,  32'hFFFFFFFC, 32'h1FC,      1, 32'hDEADBEEF, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,  32'hFFFFFFFC, 32'h1FC,      0, 32'h0,        1, 32'h1234);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rdy         = vecs[i].rdy;
            fill_valid  = vecs[i].fill;
            snoop_valid = vecs[i].snoop;
            flush       = vecs[i].flush;
            fill_addr   = vecs[i].faddr;
            fill_data   = vecs[i].fdata;
            snoop_addr  = vecs[i].saddr;
            rd_addr1    = vecs[i].rd1;
            rd_addr2    = vecs[i].rd2;
            push_exp($sformatf("vec%0d", i), vecs[i].h1, vecs[i].d1, vecs[i].h2, vecs[i].d2);
            #1;
            compare_next();
        end

        // Reset asserted mid-cycle during a fill: outputs drop at once, fill lost.
        @(negedge clk);
        rdy = 1'b1; snoop_valid = 1'b0; flush = 1'b0;
        fill_valid = 1'b1; fill_addr = 32'h60; fill_data = 32'hBEEF;
        rd_addr1 = 32'h50; rd_addr2 = 32'h60;
        push_exp("pre_rst_hit", 1'b1, 32'h9999, 1'b0, 32'h0);
        #1;
        compare_next();
        rst = 1'b1;
        #1;
        push_exp("async_rst_out", 1'b0, 32'h0, 1'b0, 32'h0);
        compare_next();
        @(negedge clk);
        rst = 1'b0; fill_valid = 1'b0;
        rd_addr1 = 32'h60; rd_addr2 = 32'h50;
        push_exp("post_rst_empty", 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        compare_next();

        // First edge after reset release accepts a fill.
        @(negedge clk);
        fill_valid = 1'b1; fill_addr = 32'h60; fill_data = 32'hCAFE;
        @(negedge clk);
        fill_valid = 1'b0;
        push_exp("first_fill_after_rst", 1'b1, 32'hCAFE, 1'b0, 32'h0);
        #1;
        compare_next();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_dual.md
ICACHE_DUAL -- requirements
Module: icache_dual

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter IDX_W, default 7, index width; entry count is 2^IDX_W (128).
REQ-003 Tag width SHALL be ADDR_W-IDX_W-2; index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; addr[1:0] ignored.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rdy  input  1  global enable; low freezes all state.
REQ-007 rd_addr1  input  ADDR_W  lookup address, port 1 (fetch PC).
REQ-008 rd_addr2  input  ADDR_W  lookup address, port 2 (fetch next PC).
REQ-009 hit1  output  1  port 1 hit.
REQ-010 data1  output  32  port 1 instruction word.
REQ-011 hit2  output  1  port 2 hit.
REQ-012 data2  output  32  port 2 instruction word.
REQ-013 fill_valid  input  1  one-cycle pulse: memory read of an instruction word completed.
REQ-014 fill_addr  input  ADDR_W  address of filled word.
REQ-015 fill_data  input  32  filled instruction word.
REQ-016 snoop_valid  input  1  one-cycle pulse: data store to snoop_addr.
REQ-017 snoop_addr  input  ADDR_W  store address.
REQ-018 flush  input  1  invalidate entire cache.

Function
REQ-019 Direct-mapped, one 32-bit word per line; per entry: valid bit, tag, data.
REQ-020 Lookups SHALL be combinational, zero latency, both ports independent, from registered array state only.
REQ-021 hitN = valid[idx] && tag[idx]==tag(rd_addrN); dataN = stored word on hit, 32'h0 on miss.
REQ-022 No fill bypass: a word filled at edge T is visible as a hit only in the cycle after T.
REQ-023 On rising edge with rdy=1 and fill_valid=1: write tag, data, set valid at fill index; overwrites any prior entry.
REQ-024 On rising edge with rdy=1 and snoop_valid=1: clear valid at snoop index only if valid and tag matches snoop tag; mismatching entry untouched.
REQ-025 Fill and snoop same edge, same index and same tag: entry SHALL end invalid (snoop wins).
REQ-026 Fill and snoop same edge, different index: both SHALL take effect.
REQ-027 flush=1 with rdy=1: all valid bits cleared at the edge; overrides fill and snoop in that cycle (no entry valid afterwards).
REQ-028 rdy=0: fill, snoop and flush ignored; lookups remain active.
REQ-029 fill_valid with rd_addr1 == fill_addr in same cycle: hit1 reflects pre-edge state (miss if not already present).
REQ-030 Tag/data arrays need no reset; only valid bits are reset.

Reset
REQ-031 rst SHALL asynchronously clear all valid bits; hit1=hit2=0 and data1=data2=32'h0 immediately while rst high.
REQ-032 rst asserted during a fill_valid cycle: fill discarded, entry invalid after reset.
REQ-033 After rst deasserts, first fill accepted on the first rising edge with rdy=1.

Verification
REQ-034 Reset, rd_addr1=0x0000_0000 -> hit1=0, data1=0x0000_0000.
REQ-035 Fill addr 0x0000_0010 data 0x0000_0513; next cycle rd_addr1=0x10, rd_addr2=0x14 -> hit1=1 data1=0x0000_0513, hit2=0 data2=0.
REQ-036 Entry 0x10 valid; fill 0x0000_0210 (same index, tag 1) data 0x0010_0093 -> rd_addr1=0x10 miss, rd_addr1=0x210 hit with 0x0010_0093.
REQ-037 Entry 0x10 valid; snoop 0x210 -> 0x10 still hits; snoop 0x10 -> 0x10 misses.
REQ-038 Same edge fill 0x20 and snoop 0x20 -> miss on 0x20; same edge fill 0x24 and flush -> miss on 0x24 and all prior entries.
REQ-039 rdy=0 with fill_valid pulse at 0x30 -> 0x30 still misses after rdy returns high.
